// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (fetch / data) arbiter in front of a single-port memory.
//   clk, rst (async, active-low)
//   if_req/if_addr            -> if_gnt, if_rvalid, if_rdata, if_stall   (fetch, read-only)
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_gnt, dm_rvalid, dm_rdata, dm_stall (data, read/write)
//   mem_memR/mem_memWR/mem_addR/mem_addWR/mem_dataWR, mem_dataR          (shared memory port)
// Each transaction is grant -> access -> response; a new grant may overlap the response.
// Define ARB_RR_EN to alternate the winner under contention; otherwise dm always wins.
module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              if_stall,
  output logic              dm_stall,
  output logic              mem_memR,
  output logic              mem_memWR,
  output logic [ADDR_W-1:0] mem_addR,
  output logic [ADDR_W-1:0] mem_addWR,
  output logic [DATA_W-1:0] mem_dataWR,
  input  logic [DATA_W-1:0] mem_dataR
);
  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;
  state_t state_q, state_d;
  logic win_dm_q, we_q, arb, gnt, pick_dm;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  // Grants are suppressed while reset is held so nothing leaks out combinationally.
  assign arb = rst && state_q != ACC;
  assign gnt = arb && (if_req || dm_req);
`ifdef ARB_RR_EN
  // prio_dm_q set means dm wins the next contended cycle; it flips to the loser after every grant.
  logic prio_dm_q;
  assign pick_dm = dm_req && (!if_req || prio_dm_q);
  always_ff @(posedge clk or negedge rst)
    if (!rst) prio_dm_q <= 1'b1;
    else if (gnt) prio_dm_q <= !pick_dm;
`else
  assign pick_dm = dm_req;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb state_d = gnt ? ACC : state_q == ACC ? RESP : IDLE;
  always_comb begin
    if_gnt    = gnt && !pick_dm;
    dm_gnt    = gnt && pick_dm;
    if_stall  = if_req && !if_gnt;
    dm_stall  = dm_req && !dm_gnt;
    mem_memR  = state_q == ACC && !we_q;
    mem_memWR = state_q == ACC && we_q;
    if_rvalid = state_q == RESP && !win_dm_q;
    dm_rvalid = state_q == RESP && win_dm_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      win_dm_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (gnt) begin
        win_dm_q <= pick_dm;
        we_q     <= pick_dm && dm_we;
        addr_q   <= pick_dm ? dm_addr : if_addr;
        wdata_q  <= pick_dm ? dm_wdata : wdata_q;
      end
      if (mem_memR) rdata_q <= mem_dataR;
    end
  assign mem_addR   = addr_q;
  assign mem_addWR  = addr_q;
  assign mem_dataWR = wdata_q;
  assign if_rdata   = rdata_q;
  assign dm_rdata   = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven, directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic if_req = 0, dm_req = 0, dm_we = 0;
  logic [11:0] if_addr = 0, dm_addr = 0;
  logic [15:0] dm_wdata = 0;
  logic if_gnt, if_rvalid, dm_gnt, dm_rvalid, if_stall, dm_stall, mem_memR, mem_memWR;
  logic [15:0] if_rdata, dm_rdata, mem_dataWR, mem_dataR;
  logic [11:0] mem_addR, mem_addWR;
  logic [15:0] ram [4096];
  logic [15:0] ref_mem [4096];
  int checks = 0, errors = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .if_stall(if_stall), .dm_stall(dm_stall),
    .mem_memR(mem_memR), .mem_memWR(mem_memWR), .mem_addR(mem_addR), .mem_addWR(mem_addWR),
    .mem_dataWR(mem_dataWR), .mem_dataR(mem_dataR)
  );

  always #5 clk = ~clk;
  assign mem_dataR = ram[mem_addR];
  always @(posedge clk) if (mem_memWR) ram[mem_addWR] <= mem_dataWR;

  // Transaction-level model: a transaction granted in cycle N accesses memory in N+1 and responds in N+2.
  typedef struct packed {logic v, dm, we; logic [11:0] addr; logic [15:0] wdata;} txn_t;
  txn_t t1, t2, nxt;
  logic [15:0] last_rd;
  logic dm_pref, exp_ig, exp_dg;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    t1 = '0; t2 = '0; nxt = '0; last_rd = '0; dm_pref = 1'b1;
  endtask

  // Entered just after a rising edge: drive inputs, then check outputs mid-cycle.
  task automatic half(input logic ir, input logic [11:0] ia, input logic dr, input logic dw,
                      input logic [11:0] da, input logic [15:0] dd);
    logic n_dm;
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
    #4;
    n_dm = RR ? (dr && (!ir || dm_pref)) : dr;
    nxt.v = !t1.v && (ir || dr);
    nxt.dm = n_dm;
    nxt.we = n_dm && dw;
    nxt.addr = n_dm ? da : ia;
    nxt.wdata = dd;
    exp_ig = nxt.v && !n_dm;
    exp_dg = nxt.v && n_dm;
    chk("if_gnt", if_gnt, exp_ig);
    chk("dm_gnt", dm_gnt, exp_dg);
    chk("if_stall", if_stall, ir && !exp_ig);
    chk("dm_stall", dm_stall, dr && !exp_dg);
    chk("mem_memR", mem_memR, t1.v && !t1.we);
    chk("mem_memWR", mem_memWR, t1.v && t1.we);
    if (t1.v) begin
      chk("mem_addR", mem_addR, t1.addr);
      chk("mem_addWR", mem_addWR, t1.addr);
    end
    if (t1.v && t1.we) chk("mem_dataWR", mem_dataWR, t1.wdata);
    chk("if_rvalid", if_rvalid, t2.v && !t2.dm);
    chk("dm_rvalid", dm_rvalid, t2.v && t2.dm);
    chk("if_rdata", if_rdata, last_rd);
    chk("dm_rdata", dm_rdata, last_rd);
  endtask

  task automatic tick();
    @(posedge clk);
    if (t1.v) begin
      if (t1.we) ref_mem[t1.addr] = t1.wdata;
      else last_rd = ref_mem[t1.addr];
    end
    if (nxt.v) dm_pref = !nxt.dm;
    t2 = t1; t1 = nxt;
    #1;
  endtask

  // Holds reset across one edge with both requests high; returns in the first cycle after release.
  task automatic do_reset();
    rst = 0; if_req = 1; dm_req = 1;
    #2;
    chk("rst if_gnt", if_gnt, 0);
    chk("rst dm_gnt", dm_gnt, 0);
    chk("rst mem_memR", mem_memR, 0);
    chk("rst mem_memWR", mem_memWR, 0);
    chk("rst if_rvalid", if_rvalid, 0);
    chk("rst dm_rvalid", dm_rvalid, 0);
    chk("rst rdata", if_rdata, 0);
    @(posedge clk); #1;
    rst = 1; if_req = 0; dm_req = 0;
    model_reset();
  endtask

  typedef struct {
    bit rst_b4, ir; logic [11:0] ia; bit dr, dw; logic [11:0] da; logic [15:0] dd;
    bit eig, edg, eir, edr; logic [15:0] erd;
  } vec_t;

  function automatic vec_t mk(bit rb, bit ir, logic [11:0] ia, bit dr, bit dw, logic [11:0] da,
                              logic [15:0] dd, bit eig, bit edg, bit eir, bit edr, logic [15:0] erd);
    mk = '{rb, ir, ia, dr, dw, da, dd, eig, edg, eir, edr, erd};
  endfunction

  vec_t tbl [14];
  logic [15:0] got [4];

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
    for (int i = 0; i < 4; i++) ram[i] = 16'h0F00 + 16'(i) * 16'h1111;
    ram[5] = 16'h1234; ram[12'h010] = 16'hA010; ram[12'h020] = 16'hD020;
    for (int i = 0; i < 4096; i++) ref_mem[i] = ram[i];
    model_reset();
    tbl[0]  = mk(1, 1, 12'h005, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h1234);
    tbl[3]  = mk(0, 0, 0, 1, 1, 12'h0A0, 16'hBEEF, 0, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 1, 0, 12'h0A0, 0, 0, 1, 0, 1, 16'h1234);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hBEEF);
    tbl[8]  = mk(1, 1, 12'h010, 1, 0, 12'h020, 0, 0, 1, 0, 0, 0);
    tbl[9]  = mk(0, 1, 12'h010, 1, 0, 12'h020, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 1, 12'h010, 1, 0, 12'h020, 0, RR, !RR, 0, 1, 16'hD020);
    tbl[11] = mk(0, 1, 12'h010, 1, 0, 12'h020, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 1, 12'h010, 1, 0, 12'h020, 0, 0, 1, RR, !RR, RR ? 16'hA010 : 16'hD020);
    tbl[13] = mk(0, 1, 12'h010, 1, 0, 12'h020, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      if (tbl[i].rst_b4) do_reset();
      half(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
      chk($sformatf("tbl%0d if_gnt", i), if_gnt, tbl[i].eig);
      chk($sformatf("tbl%0d dm_gnt", i), dm_gnt, tbl[i].edg);
      chk($sformatf("tbl%0d if_rvalid", i), if_rvalid, tbl[i].eir);
      chk($sformatf("tbl%0d dm_rvalid", i), dm_rvalid, tbl[i].edr);
      if (tbl[i].eir) chk($sformatf("tbl%0d if_rdata", i), if_rdata, tbl[i].erd);
      if (tbl[i].edr) chk($sformatf("tbl%0d dm_rdata", i), dm_rdata, tbl[i].erd);
      if (tbl[i].ir && !tbl[i].eig) chk($sformatf("tbl%0d if_stall", i), if_stall, 1);
      tick();
    end

    // Reset asserted in the middle of a read access.
    do_reset();
    half(1, 12'h003, 0, 0, 0, 0);
    tick();
    if_req = 0;
    #2;
    chk("acc mem_memR before rst", mem_memR, 1);
    rst = 0;
    #1;
    chk("async mem_memR drop", mem_memR, 0);
    chk("async mem_addR clear", mem_addR, 0);
    @(posedge clk); #1;
    chk("abandoned if_rvalid", if_rvalid, 0);
    rst = 1;
    model_reset();
    half(1, 12'h004, 0, 0, 0, 0);
    chk("first grant after rst", if_gnt, 1);
    tick();
    for (int c = 0; c < 2; c++) begin half(0, 0, 0, 0, 0, 0); tick(); end

    // Continuous fetch stream over addresses 0..3.
    begin
      int a, seen;
      do_reset();
      a = 0; seen = 0;
      for (int c = 0; c < 20 && seen < 4; c++) begin
        half(a < 4, 12'(a), 0, 0, 0, 0);
        if (if_rvalid) begin got[seen] = if_rdata; seen++; end
        if (exp_ig) a++;
        tick();
      end
      chk("stream rvalid count", 32'(seen), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("stream data %0d", i), got[i], 16'h0F00 + 16'(i) * 16'h1111);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      half(1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           12'($urandom_range(0, 63)), 16'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
